// File: rtl/fptd_iter_sched.sv
// Iteration scheduler for the fully parallel turbo decoder: sequences load/clear,
// alternating odd/even half-iterations, drain and the decoded-frame handshake.
module fptd_iter_sched #(
  parameter int ITER_W    = 6,
  parameter int HALF_CYC  = 2,
  parameter int DRAIN_CYC = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              early_stop,
  input  logic              abort,
  output logic              load_en,
  output logic              clear_state,
  output logic              odd_en,
  output logic              even_en,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iters_used
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ODD   = 3'd2;
  localparam logic [2:0] S_EVEN  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] HALF_LAST  = 4'(HALF_CYC - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  logic [2:0]        state;
  logic [3:0]        hcnt;
  logic [ITER_W-1:0] target;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] used_q;
  logic [ITER_W-1:0] iter_nxt;
  logic              half_last;
  logic              done_hit;

  assign iter_nxt  = iter_q + ITER_W'(1);
  assign half_last = (hcnt == HALF_LAST);
  // Only consulted in the final EVEN cycle, so early_stop is ignored elsewhere.
  assign done_hit  = (iter_nxt == target) || early_stop;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= S_IDLE;
      hcnt   <= '0;
      target <= '0;
      iter_q <= '0;
      used_q <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
      hcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            target <= (num_iter == '0) ? ITER_W'(1) : num_iter;
            iter_q <= '0;
            hcnt   <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          hcnt  <= '0;
          state <= S_ODD;
        end
        S_ODD: begin
          if (half_last) begin
            hcnt  <= '0;
            state <= S_EVEN;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        S_EVEN: begin
          if (half_last) begin
            hcnt <= '0;
            if (done_hit) begin
              used_q <= iter_nxt;
              state  <= (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
            end else begin
              iter_q <= iter_nxt;
              state  <= S_ODD;
            end
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (hcnt == DRAIN_LAST) begin
            hcnt  <= '0;
            state <= S_DONE;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign frame_ready = (state == S_IDLE);
  assign load_en     = (state == S_LOAD);
  assign clear_state = (state == S_LOAD);
  assign odd_en      = (state == S_ODD);
  assign even_en     = (state == S_EVEN);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign iter_cnt    = iter_q;
  assign iters_used  = used_q;

endmodule
